// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/sub with iterative align and normalise.
// Truncating rounding, denormals flushed to zero, valid/ready on both sides.
module fp_addsub_seq #(
    parameter int unsigned ALIGN_STEP = 1,
    parameter int unsigned MAX_ALIGN  = 25
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  op_code_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic [3:0]  flags_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle, StUnpack, StAlign, StAdd, StNorm, StPack, StDone
    } state_e;

    localparam logic [7:0] StepW     = 8'(ALIGN_STEP);
    localparam logic [7:0] MaxAlignW = 8'(MAX_ALIGN);

    state_e             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [30:0]        b_q, b_d;
    logic               sb_q, sb_d;
    logic               bad_op_q, bad_op_d;
    logic [23:0]        big_q, big_d;
    logic [23:0]        small_q, small_d;
    logic               big_sign_q, big_sign_d;
    logic               small_sign_q, small_sign_d;
    logic [7:0]         rem_q, rem_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [24:0]        mant_q, mant_d;
    logic               sign_q, sign_d;
    logic [31:0]        result_q, result_d;
    logic [3:0]         flags_q, flags_d;

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        sa;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [7:0]  align_step;

    assign ea     = a_q[30:23];
    assign fa     = a_q[22:0];
    assign sa     = a_q[31];
    assign eb     = b_q[30:23];
    assign fb     = b_q[22:0];
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);

    assign align_step = (rem_q < StepW) ? rem_q : StepW;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sb_d         = sb_q;
        bad_op_d     = bad_op_q;
        big_d        = big_q;
        small_d      = small_q;
        big_sign_d   = big_sign_q;
        small_sign_d = small_sign_q;
        rem_d        = rem_q;
        exp_d        = exp_q;
        mant_d       = mant_q;
        sign_d       = sign_q;
        result_d     = result_q;
        flags_d      = flags_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d      = a_i;
                    b_d      = b_i[30:0];
                    sb_d     = b_i[31] ^ (op_code_i == 3'b001);
                    bad_op_d = (op_code_i[2:1] != 2'b00);
                    state_d  = StUnpack;
                end
            end
            StUnpack: begin
                state_d = StDone;
                flags_d = 4'b0000;
                if (bad_op_q) begin
                    result_d = 32'd0;
                    flags_d  = 4'b1000;
                end else if (a_nan || b_nan || (a_inf && b_inf && (sa != sb_q))) begin
                    result_d = 32'h7FC0_0000;
                    flags_d  = 4'b0100;
                end else if (a_inf) begin
                    result_d = {sa, 8'hFF, 23'd0};
                end else if (b_inf) begin
                    result_d = {sb_q, 8'hFF, 23'd0};
                end else if (a_zero && b_zero) begin
                    result_d = {sa & sb_q, 31'd0};
                end else if (a_zero) begin
                    result_d = {sb_q, b_q};
                end else if (b_zero) begin
                    result_d = a_q;
                end else begin
                    state_d = StAlign;
                    if (ea >= eb) begin
                        big_d        = {1'b1, fa};
                        small_d      = {1'b1, fb};
                        big_sign_d   = sa;
                        small_sign_d = sb_q;
                        exp_d        = {2'b00, ea};
                        rem_d        = ea - eb;
                    end else begin
                        big_d        = {1'b1, fb};
                        small_d      = {1'b1, fa};
                        big_sign_d   = sb_q;
                        small_sign_d = sa;
                        exp_d        = {2'b00, eb};
                        rem_d        = eb - ea;
                    end
                end
            end
            StAlign: begin
                // Far-apart exponents collapse to a single cycle instead of shifting out.
                if (rem_q >= MaxAlignW) begin
                    small_d = 24'd0;
                    rem_d   = 8'd0;
                    state_d = StAdd;
                end else begin
                    small_d = small_q >> align_step;
                    rem_d   = rem_q - align_step;
                    if (rem_q == align_step) state_d = StAdd;
                end
            end
            StAdd: begin
                state_d = StNorm;
                if (big_sign_q == small_sign_q) begin
                    mant_d = {1'b0, big_q} + {1'b0, small_q};
                    sign_d = big_sign_q;
                end else if (big_q > small_q) begin
                    mant_d = {1'b0, big_q - small_q};
                    sign_d = big_sign_q;
                end else if (big_q < small_q) begin
                    mant_d = {1'b0, small_q - big_q};
                    sign_d = small_sign_q;
                end else begin
                    mant_d = 25'd0;
                    sign_d = 1'b0;
                end
            end
            StNorm: begin
                if (mant_q == 25'd0) begin
                    sign_d  = 1'b0;
                    state_d = StPack;
                end else if (mant_q[24]) begin
                    mant_d  = mant_q >> 1;
                    exp_d   = exp_q + 10'sd1;
                    state_d = StPack;
                end else if (!mant_q[23]) begin
                    // Leave as soon as the bit moving into position 23 is set.
                    mant_d = {mant_q[23:0], 1'b0};
                    exp_d  = exp_q - 10'sd1;
                    if (mant_q[22]) state_d = StPack;
                end else begin
                    state_d = StPack;
                end
            end
            StPack: begin
                state_d = StDone;
                flags_d = 4'b0000;
                if (mant_q == 25'd0) begin
                    result_d = 32'd0;
                end else if (exp_q >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    flags_d  = 4'b0010;
                end else if (exp_q <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                    flags_d  = 4'b0001;
                end else begin
                    result_d = {sign_q, exp_q[7:0], mant_q[22:0]};
                end
            end
            StDone: begin
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            a_q          <= 32'd0;
            b_q          <= 31'd0;
            sb_q         <= 1'b0;
            bad_op_q     <= 1'b0;
            big_q        <= 24'd0;
            small_q      <= 24'd0;
            big_sign_q   <= 1'b0;
            small_sign_q <= 1'b0;
            rem_q        <= 8'd0;
            exp_q        <= 10'sd0;
            mant_q       <= 25'd0;
            sign_q       <= 1'b0;
            result_q     <= 32'd0;
            flags_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sb_q         <= sb_d;
            bad_op_q     <= bad_op_d;
            big_q        <= big_d;
            small_q      <= small_d;
            big_sign_q   <= big_sign_d;
            small_sign_q <= small_sign_d;
            rem_q        <= rem_d;
            exp_q        <= exp_d;
            mant_q       <= mant_d;
            sign_q       <= sign_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = (state_q == StDone);
    assign result_o    = result_q;
    assign flags_o     = flags_q;

endmodule
